// File: rtl/frame_slot_sched.sv
// Slot scheduler for the shared multi-frame buffer: tracks committed slots,
// sequences CC/LPC transmitter starts and frees slots once every queued consumer is done.
module frame_slot_sched #(
    parameter int SLOTS  = 4,
    parameter int SLOT_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              frame_rdy_i,
    input  logic              cc_en_i,
    input  logic              lpc_en_i,
    input  logic              lpc_bsy_i,
    input  logic              cc_done_i,
    input  logic              lpc_done_i,
    output logic [SLOT_W-1:0] wr_slot_o,
    output logic              cc_start_o,
    output logic [SLOT_W-1:0] cc_slot_o,
    output logic              lpc_start_o,
    output logic [SLOT_W-1:0] lpc_slot_o,
    output logic [SLOT_W:0]   level_o,
    output logic              full_o,
    output logic [7:0]        drop_cnt_o
);

    typedef enum logic {ST_IDLE, ST_BUSY} cons_state_e;

    localparam logic [SLOT_W:0] FULL_LVL = (SLOT_W+1)'(SLOTS);
    localparam logic [SLOT_W:0] PTR_ONE  = (SLOT_W+1)'(1);

    logic [SLOT_W:0]          wr_ptr_q, wr_ptr_d;
    logic [SLOT_W:0]          tail_ptr_q, tail_ptr_d;
    logic [SLOT_W:0]          cc_ptr_q, cc_ptr_d;
    logic [SLOT_W:0]          lpc_ptr_q, lpc_ptr_d;
    logic [SLOTS-1:0][1:0]    pending_q, pending_d;
    cons_state_e              cc_state_q, cc_state_d;
    cons_state_e              lpc_state_q, lpc_state_d;
    logic                     cc_start_q, cc_start_d;
    logic                     lpc_start_q, lpc_start_d;
    logic [7:0]               drop_cnt_q, drop_cnt_d;

    logic [SLOT_W:0]          level;
    logic                     full;
    logic                     commit;
    logic                     drop;
    logic [SLOT_W-1:0]        wr_idx, tail_idx, cc_idx, lpc_idx;

    assign wr_idx   = wr_ptr_q[SLOT_W-1:0];
    assign tail_idx = tail_ptr_q[SLOT_W-1:0];
    assign cc_idx   = cc_ptr_q[SLOT_W-1:0];
    assign lpc_idx  = lpc_ptr_q[SLOT_W-1:0];

    // Wrap bit in the pointer MSB lets level distinguish full from empty.
    assign level  = wr_ptr_q - tail_ptr_q;
    assign full   = (level == FULL_LVL);
    assign commit = frame_rdy_i && !full && (cc_en_i || lpc_en_i);
    assign drop   = frame_rdy_i && full;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        tail_ptr_d  = tail_ptr_q;
        cc_ptr_d    = cc_ptr_q;
        lpc_ptr_d   = lpc_ptr_q;
        pending_d   = pending_q;
        cc_state_d  = cc_state_q;
        lpc_state_d = lpc_state_q;
        cc_start_d  = 1'b0;
        lpc_start_d = 1'b0;
        drop_cnt_d  = drop_cnt_q;

        case (cc_state_q)
            ST_IDLE: begin
                if (cc_ptr_q != wr_ptr_q) begin
                    if (pending_q[cc_idx][0]) begin
                        cc_start_d = 1'b1;
                        cc_state_d = ST_BUSY;
                    end else begin
                        cc_ptr_d = cc_ptr_q + PTR_ONE;
                    end
                end
            end
            ST_BUSY: begin
                if (cc_done_i) begin
                    pending_d[cc_idx][0] = 1'b0;
                    cc_ptr_d             = cc_ptr_q + PTR_ONE;
                    cc_state_d           = ST_IDLE;
                end
            end
            default: cc_state_d = ST_IDLE;
        endcase

        case (lpc_state_q)
            ST_IDLE: begin
                if (lpc_ptr_q != wr_ptr_q) begin
                    if (!pending_q[lpc_idx][1]) begin
                        lpc_ptr_d = lpc_ptr_q + PTR_ONE;
                    end else if (!lpc_bsy_i) begin
                        lpc_start_d = 1'b1;
                        lpc_state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (lpc_done_i) begin
                    pending_d[lpc_idx][1] = 1'b0;
                    lpc_ptr_d             = lpc_ptr_q + PTR_ONE;
                    lpc_state_d           = ST_IDLE;
                end
            end
            default: lpc_state_d = ST_IDLE;
        endcase

        if ((tail_ptr_q != wr_ptr_q) && (pending_q[tail_idx] == 2'b00)) begin
            tail_ptr_d = tail_ptr_q + PTR_ONE;
        end

        // A non-full buffer never has a busy consumer on wr_slot, so this cannot collide with a clear.
        if (commit) begin
            pending_d[wr_idx] = {lpc_en_i, cc_en_i};
            wr_ptr_d          = wr_ptr_q + PTR_ONE;
        end

        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            tail_ptr_q  <= '0;
            cc_ptr_q    <= '0;
            lpc_ptr_q   <= '0;
            pending_q   <= '0;
            cc_state_q  <= ST_IDLE;
            lpc_state_q <= ST_IDLE;
            cc_start_q  <= 1'b0;
            lpc_start_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            tail_ptr_q  <= tail_ptr_d;
            cc_ptr_q    <= cc_ptr_d;
            lpc_ptr_q   <= lpc_ptr_d;
            pending_q   <= pending_d;
            cc_state_q  <= cc_state_d;
            lpc_state_q <= lpc_state_d;
            cc_start_q  <= cc_start_d;
            lpc_start_q <= lpc_start_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign wr_slot_o   = wr_idx;
    assign cc_start_o  = cc_start_q;
    assign cc_slot_o   = cc_idx;
    assign lpc_start_o = lpc_start_q;
    assign lpc_slot_o  = lpc_idx;
    assign level_o     = level;
    assign full_o      = full;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: doc/frame_slot_sched.md
# frame_slot_sched

Slot scheduler for the multi-frame sound/flight buffer between the frame assembler and the two serial transmitters (CC and LPC). It tracks which frame slots hold committed frames, issues per-slot start pulses to each enabled transmitter in order, frees a slot once every transmitter it was queued for has finished with it, and drops frames when all slots are occupied. It owns no data RAM. It only produces slot indices that the assembler and transmitters use as the upper address bits of the shared buffer.

## Interface
- SLOTS, 4: number of frame slots; power of two, at least 2.
- SLOT_W, 2: log2(SLOTS).

- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- frame_rdy  in  1  one-cycle pulse from the assembler; the frame in wr_slot is complete.
- cc_en  in  1  CC transmitter enabled; sampled at commit.
- lpc_en  in  1  LPC transmitter enabled; sampled at commit.
- lpc_bsy  in  1  LPC host busy; blocks new LPC starts.
- cc_done  in  1  one-cycle pulse; CC finished its current slot.
- lpc_done  in  1  one-cycle pulse; LPC finished its current slot.
- wr_slot  out  SLOT_W  slot the assembler is writing.
- cc_start  out  1  one-cycle pulse; CC must send cc_slot.
- cc_slot  out  SLOT_W  slot for CC; held stable while CC is busy.
- lpc_start  out  1  one-cycle pulse; LPC must send lpc_slot.
- lpc_slot  out  SLOT_W  slot for LPC; held stable while LPC is busy.
- level  out  SLOT_W+1  occupied slots, 0..SLOTS.
- full  out  1  level == SLOTS.
- drop_cnt  out  8  dropped frames; saturates at 255.

## Operation
- Pointers: wr_ptr, tail_ptr, cc_ptr and lpc_ptr are each SLOT_W+1 bits, with the MSB as the wrap bit. Slot index = ptr[SLOT_W-1:0].
- level = wr_ptr - tail_ptr, computed modulo 2^(SLOT_W+1).
- Each slot holds a pending[1:0] register, with bit 0 for CC and bit 1 for LPC.
- Commit: frame_rdy is high, full is low, and cc_en or lpc_en is high.
  - pending[wr_slot] <= {lpc_en, cc_en}.
  - wr_ptr increments.
- Discard: frame_rdy is high and both enables are low. Pointers and counters do not change, and the assembler rewrites the same slot.
- Drop: frame_rdy is high and full is high.
  - wr_ptr is held.
  - drop_cnt increments, saturating at 255.
- Free: if tail_ptr != wr_ptr and pending[tail] == 0, tail_ptr increments. At most one slot is freed per cycle.
- Consumer FSM, one per transmitter; states IDLE and BUSY. The description below is for CC; LPC is identical except where noted.
  - IDLE, with cc_ptr == wr_ptr: wait.
  - IDLE, with cc_ptr != wr_ptr and pending[cc_ptr][0] == 0: cc_ptr increments (skip the slot). Stay in IDLE.
  - IDLE, with cc_ptr != wr_ptr and pending[cc_ptr][0] == 1: pulse cc_start, then go to BUSY.
  - LPC only: the IDLE-to-BUSY transition additionally requires lpc_bsy == 0.
  - BUSY, on cc_done: clear pending[cc_ptr][0], cc_ptr increments, go to IDLE.
  - A done pulse while in IDLE is ignored.
- cc_slot = cc_ptr[SLOT_W-1:0] and lpc_slot = lpc_ptr[SLOT_W-1:0], both driven combinationally.
- Consumer pointers never pass wr_ptr. tail_ptr never passes either consumer pointer, because a slot stays pending until both its bits clear.
- Enables are sampled only at commit. Deasserting an enable later does not cancel queued work.

## Timing
- Reset values:
  - All pointers are 0; all pending bits are 0; both FSMs are in IDLE.
  - Outputs: wr_slot = 0, cc_slot = 0, lpc_slot = 0, level = 0, full = 0, drop_cnt = 0, cc_start = 0, lpc_start = 0.
- Reset mid-transfer abandons all queued frames. No done pulse is required afterwards.
- All state is registered. full and level reflect the state at the start of the cycle.
- Commit to start: cc_start/lpc_start is asserted in the cycle after the wr_ptr update, giving 2 cycles of latency from frame_rdy.
- Each skipped slot costs 1 cycle.
- Done to next start: done in cycle N means the FSM is in IDLE in N+1 and issues the next start in N+2 at the earliest.
- Slot free: the last done in cycle N clears pending in N+1. tail_ptr advances at the end of N+1, so full deasserts in N+2.
  - A frame_rdy at or before N+1 with full high is a drop.
- Same-cycle events are independent:
  - Commit and free in the same cycle: level stays unchanged.
  - cc_done and lpc_done in the same cycle both take effect.
  - Commit, free and both dones can all occur in the same cycle.
- Wrap: pointer arithmetic is modulo 2^(SLOT_W+1). After 2^(SLOT_W+1) commits, wr_ptr == 0 with no spurious full or empty.

## Test plan
- Single frame, both consumers enabled: frame_rdy at t0 → wr_slot = 1 at t1; cc_start and lpc_start with slot 0 at t2; cc_done at t5 and lpc_done at t8 → level 1→0 at t10.
- LPC backpressure: lpc_bsy = 1 for 20 cycles over one committed frame → CC starts at t2; lpc_start is asserted 1 cycle after lpc_bsy falls, with lpc_slot = 0.
- Overflow, SLOTS = 4, no dones: 6 frame_rdy pulses → level = 4, full = 1, drop_cnt = 2, wr_slot = 0.
  - Then cc_done and lpc_done for slot 0 → full = 0 two cycles after the later done.
- Selective enable: commit 3 frames with cc_en = 1, lpc_en = 0 → LPC starts nothing and each slot frees after cc_done alone.
  - Then commit with lpc_en = 1 → lpc_ptr skips 3 slots (3 cycles) and starts slot 3.
- Wraparound and saturation: 300 frames, each completed by both consumers → no drops, and the slot sequence is 0,1,2,3 repeating.
  - Repeat without dones: drop_cnt stops at 255.
- Reset mid-operation: assert reset while both FSMs are BUSY with level = 3 → next cycle every output is at its reset value, and stale done pulses are ignored.
